// File: rtl/sub_bytes_iter.sv
`default_nettype none
// ============================================================================
//  Module   : sub_bytes_iter (with helper s_box)
//  Purpose  : Iterative AES SubBytes stage. A 128-bit state is captured, its
//             16 bytes are substituted LANES at a time through combinational
//             S-box lanes over 16/LANES cycles, and the result is presented
//             on a valid/ready output.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             in_valid/in_ready - input handshake, in_state = 128-bit state
//             out_valid/out_ready - output handshake, out_state = result
//             busy              - high while substitution is in progress
//  Bytes    : byte i lives at [127-8i -: 8] (byte 0 at the MSB).
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  s_box : combinational AES forward S-box, one byte in, one byte out.
// ----------------------------------------------------------------------------
module s_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Table entry for input x sits at [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TABLE[2047 - 8*int'(in_byte) -: 8];
endmodule

// ----------------------------------------------------------------------------
//  sub_bytes_iter : top level
// ----------------------------------------------------------------------------
module sub_bytes_iter #(
    parameter int LANES = 4             // 1, 2, 4, 8 or 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int GRPS = 16 / LANES;
    localparam int GW   = (GRPS > 1) ? $clog2(GRPS) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(GRPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [127:0]    r_st;
    logic [GW-1:0]   r_grp;

    logic [7:0]      w_lane_in  [LANES];
    logic [7:0]      w_lane_out [LANES];
    logic [127:0]    w_st_next;

    // Lane l works on byte grp*LANES + l of the working register.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_in[l] = r_st[127 - 8*(int'(r_grp)*LANES + l) -: 8];
        end
    end

    // Kept in a separate block from the lane-input select so the S-box
    // outputs do not feed back into the process that drives their inputs.
    always_comb begin
        w_st_next = r_st;
        for (int l = 0; l < LANES; l++) begin
            w_st_next[127 - 8*(int'(r_grp)*LANES + l) -: 8] = w_lane_out[l];
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            s_box u_s_box (
                .in_byte  (w_lane_in[g]),
                .out_byte (w_lane_out[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_st    <= '0;
            r_grp   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_st    <= in_state;
                        r_grp   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_st <= w_st_next;
                    if (r_grp == LAST_GRP) begin
                        r_grp   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register, so neither
    // in_valid nor out_ready has a combinational path to an output.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN);
    assign out_state = r_st;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sub_bytes_iter
//  Purpose  : Directed self-checking bench for sub_bytes_iter. Five copies
//             (LANES = 1, 2, 4, 8, 16; index i has LANES = 1<<i) share all
//             inputs; index 2 (LANES = 4) is the main device under test.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_iter;

    localparam logic [127:0] C_FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] C_FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] C_ALL_63   = {16{8'h63}};
    localparam logic [127:0] C_ALL_23   = {16{8'h23}};
    localparam logic [127:0] C_ALL_26   = {16{8'h26}};
    localparam logic [127:0] C_ALL_53   = {16{8'h53}};
    localparam logic [127:0] C_ALL_ED   = {16{8'hED}};
    localparam logic [127:0] C_POS_IN   = {8'hFF, {14{8'h00}}, 8'h53};
    localparam logic [127:0] C_POS_OUT  = {8'h16, {14{8'h63}}, 8'hED};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_state;
    logic         out_ready;
    logic [4:0]   in_ready;
    logic [4:0]   out_valid;
    logic [4:0]   busy;
    logic [127:0] out_state [5];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_dut
            sub_bytes_iter #(.LANES(1 << gi)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready[gi]),
                .in_state  (in_state),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready),
                .out_state (out_state[gi]),
                .busy      (busy[gi])
            );
        end
    endgenerate

    // Advance one rising edge; inputs are then driven and outputs sampled
    // 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_state = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present one state for exactly one edge (the acceptance edge T).
    task automatic send(input logic [127:0] s);
        in_valid = 1'b1;
        in_state = s;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid[i]; -1 if bound expires.
    task automatic wait_valid(input int i, input int max, output int lat);
        lat = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (out_valid[i]) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (in_ready !== 5'h1f) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want %b", in_ready, 5'h1f);
        end
        n_cmp++;
        if (out_valid !== 5'h00 || busy !== 5'h00) begin
            n_bad++; $display("FAIL reset_flags: got out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
        n_cmp++;
        if (out_state[2] !== 128'h0) begin
            n_bad++; $display("FAIL reset_out_state: got %h want 0", out_state[2]);
        end
        // Reset together with in_valid: nothing may be accepted.
        rst = 1'b1; in_valid = 1'b1; in_state = C_FIPS_IN;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (busy !== 5'h00 || in_ready !== 5'h1f) begin
            n_bad++; $display("FAIL reset_wins: got busy=%b in_ready=%b want 00000/11111", busy, in_ready);
        end
    endtask

    task automatic test_zero_state();
        int lat;
        do_reset();
        out_ready = 1'b1;
        send(128'h0);
        wait_valid(2, 10, lat);
        n_cmp++;
        if (lat !== 4) begin
            n_bad++; $display("FAIL zero_latency: got %0d want 4", lat);
        end
        n_cmp++;
        if (out_state[2] !== C_ALL_63) begin
            n_bad++; $display("FAIL zero_data: got %h want %h", out_state[2], C_ALL_63);
        end
        tick();
        n_cmp++;
        if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1) begin
            n_bad++; $display("FAIL zero_one_cycle: got out_valid=%b in_ready=%b want 0/1", out_valid[2], in_ready[2]);
        end
    endtask

    task automatic test_fips_all_lanes();
        int  lat [5];
        bit  seen [5];
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lat[i] = -1; seen[i] = 1'b0;
        end
        send(C_FIPS_IN);
        for (int k = 1; k <= 20; k++) begin
            tick();
            for (int i = 0; i < 5; i++) begin
                if (out_valid[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = k;
                    n_cmp++;
                    if (out_state[i] !== C_FIPS_OUT) begin
                        n_bad++; $display("FAIL fips_data_lanes%0d: got %h want %h", 1 << i, out_state[i], C_FIPS_OUT);
                    end
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (lat[i] !== (16 >> i)) begin
                n_bad++; $display("FAIL fips_latency_lanes%0d: got %0d want %0d", 1 << i, lat[i], 16 >> i);
            end
        end
    endtask

    task automatic test_byte_position();
        int lat;
        do_reset();
        out_ready = 1'b1;
        send(C_POS_IN);
        wait_valid(2, 10, lat);
        n_cmp++;
        if (lat !== 4 || out_state[2] !== C_POS_OUT) begin
            n_bad++; $display("FAIL byte_position: got lat=%0d %h want lat=4 %h", lat, out_state[2], C_POS_OUT);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad_cycles;
        do_reset();
        out_ready = 1'b0;
        send(C_FIPS_IN);
        wait_valid(2, 10, lat);
        n_cmp++;
        if (lat !== 4) begin
            n_bad++; $display("FAIL bp_latency: got %0d want 4", lat);
        end
        bad_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k == 3);        // stray pulse must be ignored
            in_state = C_ALL_53;
            tick();
            if (out_valid[2] !== 1'b1 || in_ready[2] !== 1'b0 || out_state[2] !== C_FIPS_OUT)
                bad_cycles++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (bad_cycles !== 0) begin
            n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0 (last %h)", bad_cycles, out_state[2]);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1 || busy[2] !== 1'b0) begin
            n_bad++; $display("FAIL bp_release: got out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid[2], in_ready[2], busy[2]);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int stray;
        do_reset();
        out_ready = 1'b1;
        send({16{8'h11}});
        tick();                          // now in the 2nd RUN cycle
        n_cmp++;
        if (busy[0] !== 1'b1) begin
            n_bad++; $display("FAIL midrun_busy: got %b want 1", busy[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_bad++; $display("FAIL midrun_reset: got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready[0], out_valid[0], busy[0]);
        end
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid[0]) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL midrun_discard: got %0d valid cycles want 0", stray);
        end
        send(C_ALL_23);
        wait_valid(0, 20, lat);
        n_cmp++;
        if (lat !== 16 || out_state[0] !== C_ALL_26) begin
            n_bad++; $display("FAIL midrun_next_block: got lat=%0d %h want lat=16 %h", lat, out_state[0], C_ALL_26);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] q_in  [3];
        logic [127:0] q_out [3];
        int  t_out [3];
        int  n_in;
        int  n_out;
        bit  acc;
        q_in[0] = C_FIPS_IN;  q_out[0] = C_FIPS_OUT;
        q_in[1] = 128'h0;     q_out[1] = C_ALL_63;
        q_in[2] = C_ALL_53;   q_out[2] = C_ALL_ED;
        do_reset();
        out_ready = 1'b1;
        n_in  = 0;
        n_out = 0;
        in_valid = 1'b1;
        in_state = q_in[0];
        for (int k = 1; k <= 40 && n_out < 3; k++) begin
            acc = in_valid && in_ready[2];
            tick();
            if (acc) begin
                n_in++;
                if (n_in < 3) in_state = q_in[n_in];
                else          in_valid = 1'b0;
            end
            if (out_valid[2]) begin
                t_out[n_out] = k;
                n_cmp++;
                if (out_state[2] !== q_out[n_out]) begin
                    n_bad++; $display("FAIL b2b_data%0d: got %h want %h", n_out, out_state[2], q_out[n_out]);
                end
                n_out++;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (n_out !== 3) begin
            n_bad++; $display("FAIL b2b_count: got %0d outputs want 3", n_out);
        end else begin
            n_cmp++;
            if (t_out[1] - t_out[0] !== 6 || t_out[2] - t_out[1] !== 6) begin
                n_bad++; $display("FAIL b2b_spacing: got %0d,%0d want 6,6", t_out[1] - t_out[0], t_out[2] - t_out[1]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
        test_reset();
        test_zero_state();
        test_fips_all_lanes();
        test_byte_position();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
